cost_port_arbiter: RTL



---
 rtl/jam_pkg.sv | 14 +
 rtl/rr_picker.sv | 28 ++
 rtl/cost_port_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/jam_pkg.sv
// Shared definitions for the assignment-search block: table port widths,
// worker count and the cost-port arbiter state encoding.
package jam_pkg;

    localparam int JAM_WJ_W   = 3;   // worker / job index width
    localparam int JAM_COST_W = 7;   // cost table data width
    localparam int JAM_NWORK  = 8;   // workers per permutation row

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: scans req_i starting at position ptr_i
// and returns the first requester found as a one-hot winner.
module rr_picker #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  win_o,
    output logic          any_o
);

    // Offset i is tried in order; the inner loop maps offset to position so
    // every bit select uses a constant index.
    always_comb begin
        win_o = '0;
        any_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int p = 0; p < N; p++) begin
                if (!any_o && (p == (int'(ptr_i) + i) % N) && req_i[p]) begin
                    win_o[p] = 1'b1;
                    any_o    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cost_port_arbiter.sv
// Shares the single job-cost table port among NREQ search engines. An owner
// streams one burst of BURST beats; the arbiter supplies W, forwards J, and
// returns each Cost to the owner tagged with W and a last-beat flag.
module cost_port_arbiter
    import jam_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int BURST = JAM_NWORK
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NREQ-1:0]          REQ,
    input  logic [NREQ-1:0]          REQ_VLD,
    input  logic [JAM_WJ_W*NREQ-1:0] REQ_J,
    output logic [NREQ-1:0]          GNT,
    output logic [JAM_WJ_W-1:0]      W,
    output logic [JAM_WJ_W-1:0]      J,
    input  logic [JAM_COST_W-1:0]    Cost,
    output logic [NREQ-1:0]          RSP_VLD,
    output logic [JAM_WJ_W-1:0]      RSP_W,
    output logic [JAM_COST_W-1:0]    RSP_COST,
    output logic                     RSP_LAST
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [JAM_WJ_W-1:0] CNT_LAST = JAM_WJ_W'(BURST - 1);
    localparam logic [PW-1:0]       PTR_LAST = PW'(NREQ - 1);

    arb_state_e              state_q, state_d;
    logic [JAM_WJ_W-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]           ptr_q, ptr_d;
    logic [NREQ-1:0]         gnt_q, gnt_d;
    logic [JAM_WJ_W-1:0]     w_q, w_d;
    logic [JAM_WJ_W-1:0]     j_q, j_d;
    logic [NREQ-1:0]         iss_q, iss_d;      // owner of the beat now on W/J
    logic [NREQ-1:0]         rsp_vld_q;
    logic [JAM_WJ_W-1:0]     rsp_w_q;
    logic [JAM_COST_W-1:0]   rsp_cost_q;
    logic                    rsp_last_q;

    logic [NREQ-1:0]         win;
    logic                    win_any;
    logic [PW-1:0]           win_idx;
    logic [PW-1:0]           nxt_ptr;
    logic [JAM_WJ_W-1:0]     owner_j;
    logic                    owner_req, owner_vld;
    logic                    beat, burst_end, abort_b, rearb;

    rr_picker #(.N(NREQ), .PW(PW)) u_pick (
        .req_i (REQ),
        .ptr_i (ptr_q),
        .win_o (win),
        .any_o (win_any)
    );

    // Encode the one-hot winner so the pointer can move just past it.
    always_comb begin
        win_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (win[k]) win_idx = PW'(k);
        end
        nxt_ptr = (win_idx == PTR_LAST) ? '0 : win_idx + 1'b1;
    end

    // Select the owner's job index; only the granted slice is ever used.
    always_comb begin
        owner_j = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_q[k]) owner_j = REQ_J[JAM_WJ_W*k +: JAM_WJ_W];
        end
    end

    assign owner_req = |(REQ & gnt_q);
    assign owner_vld = |(REQ_VLD & gnt_q);
    assign beat      = (state_q == OWN) && owner_req && owner_vld;
    assign burst_end = beat && (cnt_q == CNT_LAST);
    assign abort_b   = (state_q == OWN) && !owner_req;
    // Burst end and abort re-arbitrate in the same cycle so no idle gap appears.
    assign rearb     = (state_q == IDLE) || burst_end || abort_b;

    // Next-state for the grant FSM, beat counter and table address registers.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        j_d     = j_q;
        iss_d   = '0;
        if (beat) begin
            w_d   = cnt_q;
            j_d   = owner_j;
            iss_d = gnt_q;
            cnt_d = burst_end ? '0 : cnt_q + 1'b1;
        end
        if (abort_b) cnt_d = '0;
        if (rearb) begin
            if (win_any) begin
                state_d = OWN;
                gnt_d   = win;
                ptr_d   = nxt_ptr;
            end else begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        end
    end

    // Control and address registers; reset dominates.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            w_q     <= '0;
            j_q     <= '0;
            iss_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            j_q     <= j_d;
            iss_q   <= iss_d;
        end
    end

    // Capture the table data one cycle after the address goes out; reset drops in-flight beats.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rsp_vld_q  <= '0;
            rsp_w_q    <= '0;
            rsp_cost_q <= '0;
            rsp_last_q <= 1'b0;
        end else begin
            rsp_vld_q  <= iss_q;
            rsp_last_q <= (|iss_q) && (w_q == CNT_LAST);
            if (|iss_q) begin
                rsp_w_q    <= w_q;
                rsp_cost_q <= Cost;
            end
        end
    end

    assign GNT      = gnt_q;
    assign W        = w_q;
    assign J        = j_q;
    assign RSP_VLD  = rsp_vld_q;
    assign RSP_W    = rsp_w_q;
    assign RSP_COST = rsp_cost_q;
    assign RSP_LAST = rsp_last_q;

endmodule
